// File: rtl/gen_matrix_stream_if.sv
// rtl/gen_matrix_stream_if.sv - matrix output stream between generator and storage writer
interface gen_matrix_stream_if #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 8
);
    localparam int DW     = $clog2(MAX_DIM + 1);
    localparam int FLAT_W = MAX_DIM * MAX_DIM * ELEM_W;

    logic [FLAT_W-1:0] matrix_flat;
    logic              matrix_valid;
    logic              matrix_ready;
    logic [DW-1:0]     gen_m;
    logic [DW-1:0]     gen_n;

    modport master (
        output matrix_flat,
        output matrix_valid,
        output gen_m,
        output gen_n,
        input  matrix_ready
    );

    modport slave (
        input  matrix_flat,
        input  matrix_valid,
        input  gen_m,
        input  gen_n,
        output matrix_ready
    );
endinterface

// File: rtl/gen_matrix_stream.sv
// rtl/gen_matrix_stream.sv - random M x N matrix generator driven by ASCII digits
module gen_matrix_stream #(
    parameter int          MAX_DIM  = 5,
    parameter int          MAX_NUM  = 4,
    parameter int          ELEM_W   = 8,
    parameter int          ELEM_MIN = 0,
    parameter int          ELEM_MAX = 9,
    parameter logic [15:0] SEED     = 16'hACE1,
    localparam int         DW       = $clog2(MAX_DIM + 1),
    localparam int         CW       = $clog2(MAX_NUM + 1),
    localparam int         RANGE    = ELEM_MAX - ELEM_MIN + 1,
    localparam int         RW       = (RANGE > 1) ? $clog2(RANGE) : 1,
    localparam int         FLAT_W   = MAX_DIM * MAX_DIM * ELEM_W,
    localparam int         KW       = $clog2(MAX_DIM * MAX_DIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_seed_load,
    input  logic [15:0]         i_seed_in,
    input  logic [7:0]          i_uart_data,
    input  logic                i_uart_data_valid,
    gen_matrix_stream_if.master m_if,
    output logic [CW-1:0]       o_gen_cnt,
    output logic                o_busy,
    output logic                o_gen_done,
    output logic                o_error,
    output logic [1:0]          o_err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_M, S_RX_N, S_RX_NUM, S_CHECK, S_GEN, S_HOLD, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Digits are kept at full 0..9 width so out-of-range values are not aliased
    // into legal ones before the range check.
    logic [3:0]        r_m_dig;
    logic [3:0]        r_n_dig;
    logic [3:0]        r_num_dig;
    logic [15:0]       r_lfsr;
    logic [DW-1:0]     r_i;
    logic [DW-1:0]     r_j;
    logic [KW-1:0]     r_k;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_err_code;
    logic [FLAT_W-1:0] r_flat;

    logic              w_is_digit;
    logic [3:0]        w_digit;
    logic [RW-1:0]     w_cand;
    logic              w_accept;
    logic              w_fb;
    logic [ELEM_W-1:0] w_elem;
    logic              w_last_elem;
    logic              w_row_end;
    logic              w_last_mat;
    logic              w_dim_bad;
    logic              w_num_bad;
    logic              w_hs;
    logic              w_valid;
    logic              w_err_set;
    logic [1:0]        w_err_val;

    // For ASCII '0'..'9' the low nibble equals the digit value.
    assign w_is_digit  = (i_uart_data >= 8'h30) && (i_uart_data <= 8'h39);
    assign w_digit     = i_uart_data[3:0];

    assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand      = r_lfsr[RW-1:0];
    assign w_accept    = (32'(w_cand) < RANGE);
    assign w_elem      = ELEM_W'(ELEM_MIN) + ELEM_W'(w_cand);

    assign w_row_end   = (32'(r_j) + 1) == 32'(r_n_dig);
    assign w_last_elem = w_row_end && ((32'(r_i) + 1) == 32'(r_m_dig));
    assign w_last_mat  = (32'(r_cnt) + 1) == 32'(r_num_dig);
    assign w_dim_bad   = (r_m_dig == 4'd0) || (32'(r_m_dig) > MAX_DIM) ||
                         (r_n_dig == 4'd0) || (32'(r_n_dig) > MAX_DIM);
    assign w_num_bad   = (r_num_dig == 4'd0) || (32'(r_num_dig) > MAX_NUM);
    assign w_hs        = (r_state == S_HOLD) && m_if.matrix_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, status outputs and error cause selection
    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        w_err_val    = 2'd0;
        o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
        o_gen_done   = (r_state == S_DONE);
        o_error      = (r_state == S_ERR);
        w_valid      = (r_state == S_HOLD);
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_RX_M;
            end
            S_RX_M, S_RX_N, S_RX_NUM: begin
                if (i_uart_data_valid) begin
                    if (!w_is_digit) begin
                        w_state_next = S_ERR;
                        w_err_set    = 1'b1;
                        w_err_val    = 2'd1;
                    end else if (r_state == S_RX_M) begin
                        w_state_next = S_RX_N;
                    end else if (r_state == S_RX_N) begin
                        w_state_next = S_RX_NUM;
                    end else begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_dim_bad) begin
                    w_state_next = S_ERR;
                    w_err_set    = 1'b1;
                    w_err_val    = 2'd2;
                end else if (w_num_bad) begin
                    w_state_next = S_ERR;
                    w_err_set    = 1'b1;
                    w_err_val    = 2'd3;
                end else begin
                    w_state_next = S_GEN;
                end
            end
            S_GEN: begin
                if (w_accept && w_last_elem) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (m_if.matrix_ready) w_state_next = w_last_mat ? S_DONE : S_GEN;
            end
            S_DONE: begin
                if (!i_start) w_state_next = S_IDLE;
            end
            S_ERR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // LFSR: reseed only in IDLE, free-run in GEN, frozen elsewhere
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (r_state == S_IDLE && i_seed_load) begin
            r_lfsr <= (i_seed_in == 16'd0) ? SEED : i_seed_in;
        end else if (r_state == S_GEN) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Request parameters, element indices, matrix buffer, counters and error code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_dig    <= 4'd0;
            r_n_dig    <= 4'd0;
            r_num_dig  <= 4'd0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_err_code <= 2'd0;
            r_flat     <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_cnt      <= '0;
                r_err_code <= 2'd0;
                r_flat     <= '0;
            end
            if (i_uart_data_valid && w_is_digit) begin
                if (r_state == S_RX_M)   r_m_dig   <= w_digit;
                if (r_state == S_RX_N)   r_n_dig   <= w_digit;
                if (r_state == S_RX_NUM) r_num_dig <= w_digit;
            end
            if (r_state == S_CHECK) begin
                r_i <= '0;
                r_j <= '0;
                r_k <= '0;
            end
            if (r_state == S_GEN && w_accept) begin
                r_flat[32'(r_k)*ELEM_W +: ELEM_W] <= w_elem;
                r_k <= r_k + 1'b1;
                if (w_row_end) begin
                    r_j <= '0;
                    r_i <= r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
            if (w_hs) begin
                r_cnt  <= r_cnt + 1'b1;
                r_flat <= '0;
                r_i    <= '0;
                r_j    <= '0;
                r_k    <= '0;
            end
            if (w_err_set) r_err_code <= w_err_val;
        end
    end

    assign m_if.matrix_flat  = r_flat;
    assign m_if.matrix_valid = w_valid;
    assign m_if.gen_m        = DW'(r_m_dig);
    assign m_if.gen_n        = DW'(r_n_dig);
    assign o_gen_cnt         = r_cnt;
    assign o_err_code        = r_err_code;

endmodule

// File: tb/tb_gen_matrix_stream.sv
// tb/tb_gen_matrix_stream.sv - directed self-checking bench for gen_matrix_stream
module tb_gen_matrix_stream;

    logic        clk;
    logic        rst;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [7:0]  uart_data;
    logic        uart_data_valid;
    logic [2:0]  gen_cnt;
    logic        busy;
    logic        gen_done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    gen_matrix_stream_if #(.MAX_DIM(5), .ELEM_W(8)) m_if ();

    gen_matrix_stream dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (start),
        .i_seed_load       (seed_load),
        .i_seed_in         (seed_in),
        .i_uart_data       (uart_data),
        .i_uart_data_valid (uart_data_valid),
        .m_if              (m_if.master),
        .o_gen_cnt         (gen_cnt),
        .o_busy            (busy),
        .o_gen_done        (gen_done),
        .o_error           (error),
        .o_err_code        (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data       = b;
        uart_data_valid = 1'b1;
        tick();
        uart_data_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    // Returns the number of edges until matrix_valid, capped at 300.
    task automatic wait_valid(output int n);
        n = 0;
        while (m_if.matrix_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int                 n;
        logic [199:0]       snap;
        logic [199:0]       flat;
        logic               bad;
        logic [7:0]         exp_el [2];

        rst = 1'b0; start = 1'b0; seed_load = 1'b0; seed_in = 16'd0;
        uart_data = 8'd0; uart_data_valid = 1'b0; m_if.matrix_ready = 1'b1;

        // 2x2, one matrix, ready high: {1,3,7,9} after 7 GEN cycles
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", m_if.matrix_valid, 0);
        check("rst_done", gen_done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        check("rst_flat", m_if.matrix_flat, 0);
        check("rst_cnt", gen_cnt, 0);
        pulse_start();
        check("rx_busy", busy, 1);
        send3("2", "2", "1");
        wait_valid(n);
        check("m22_gen_cycles", n - 1, 7);
        check("m22_flat", m_if.matrix_flat, 200'h09070301);
        check("m22_gen_m", m_if.gen_m, 2);
        check("m22_gen_n", m_if.gen_n, 2);
        check("m22_cnt_hold", gen_cnt, 0);
        tick();
        check("m22_valid_fall", m_if.matrix_valid, 0);
        check("m22_done", gen_done, 1);
        check("m22_cnt", gen_cnt, 1);
        check("m22_flat_clr", m_if.matrix_flat, 0);
        tick();
        check("m22_idle", gen_done, 0);

        // 1x1 x3 with a 10-cycle stall on the first matrix
        do_reset();
        m_if.matrix_ready = 1'b0;
        pulse_start();
        send3("1", "1", "3");
        wait_valid(n);
        check("stall_first_el", m_if.matrix_flat, 200'h01);
        snap = m_if.matrix_flat;
        bad  = 1'b0;
        repeat (10) begin
            tick();
            if (m_if.matrix_valid !== 1'b1 || m_if.matrix_flat !== snap) bad = 1'b1;
        end
        check("stall_stable", bad, 0);
        m_if.matrix_ready = 1'b1;
        tick();
        check("stall_hs_valid", m_if.matrix_valid, 0);
        check("stall_hs_cnt", gen_cnt, 1);
        exp_el[0] = 8'd3;
        exp_el[1] = 8'd7;
        for (int k = 0; k < 2; k++) begin
            wait_valid(n);
            check($sformatf("stall_el%0d", k + 1), m_if.matrix_flat, 200'(exp_el[k]));
            tick();
        end
        check("stall_done", gen_done, 1);
        check("stall_cnt", gen_cnt, 3);
        tick();

        // input errors
        do_reset();
        pulse_start();
        send3("6", "2", "1");
        check("dim_err_check_cycle", error, 0);
        tick();
        check("dim_err_pulse", error, 1);
        check("dim_err_code", err_code, 2);
        tick();
        check("dim_err_one_cycle", error, 0);
        check("dim_err_code_held", err_code, 2);
        pulse_start();
        check("err_code_clr", err_code, 0);
        send3("2", "2", "0");
        tick();
        check("num_err_pulse", error, 1);
        check("num_err_code", err_code, 3);
        tick();
        pulse_start();
        send_byte("A");
        check("char_err_pulse", error, 1);
        check("char_err_code", err_code, 1);
        tick();

        // reseed
        do_reset();
        seed_in = 16'h0005; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        pulse_start();
        send3("1", "1", "1");
        wait_valid(n);
        check("seed5_el", m_if.matrix_flat, 200'h05);
        tick();
        tick();
        seed_in = 16'h0000; seed_load = 1'b1; start = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        send3("1", "1", "1");
        wait_valid(n);
        check("seed0_el", m_if.matrix_flat, 200'h01);
        tick();
        tick();

        // 5x5 x4: every element in range, then reset during the second GEN
        do_reset();
        pulse_start();
        send3("5", "5", "4");
        for (int mi = 0; mi < 4; mi++) begin
            wait_valid(n);
            check($sformatf("m55_valid%0d", mi), m_if.matrix_valid, 1);
            flat = m_if.matrix_flat;
            bad  = 1'b0;
            for (int e = 0; e < 25; e++) if (flat[e*8 +: 8] > 8'd9) bad = 1'b1;
            check($sformatf("m55_range%0d", mi), bad, 0);
            tick();
        end
        check("m55_done", gen_done, 1);
        check("m55_cnt", gen_cnt, 4);
        tick();
        pulse_start();
        send3("5", "5", "4");
        wait_valid(n);
        tick();
        repeat (3) tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", m_if.matrix_valid, 0);
        check("abort_cnt", gen_cnt, 0);
        check("abort_flat", m_if.matrix_flat, 0);
        check("abort_gen_m", m_if.gen_m, 0);
        check("abort_done", gen_done, 0);
        rst = 1'b0;
        pulse_start();
        send3("1", "1", "1");
        wait_valid(n);
        check("abort_seed_el", m_if.matrix_flat, 200'h01);
        tick();
        tick();

        // 2x3 upper bits zero; start held through DONE
        do_reset();
        m_if.matrix_ready = 1'b0;
        start = 1'b1;
        tick();
        send3("2", "3", "1");
        wait_valid(n);
        flat = m_if.matrix_flat;
        check("m23_upper_zero", flat[199:48], 0);
        check("m23_gen_m", m_if.gen_m, 2);
        check("m23_gen_n", m_if.gen_n, 3);
        m_if.matrix_ready = 1'b1;
        tick();
        check("m23_done", gen_done, 1);
        repeat (3) tick();
        check("m23_done_held", gen_done, 1);
        start = 1'b0;
        tick();
        check("m23_idle_done", gen_done, 0);
        check("m23_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
